rom_stream_sink: RTL
====================

# rom_stream_sink

Receiving end of the ROM loader byte stream. Consumes `dout`/`dout_valid`/`loading` from any loader (test loader, SD loader, UART loader) and latches the 64-byte header. Packs payload bytes into 16-bit words, buffers them in a small FIFO and issues word writes to the SDRAM ROM region over a req/ack handshake. Reports completion and overflow to the system controller.

## Interface
Parameters:
- `ADDR_W`, 22: word-address width of the ROM region (8 MB).
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, at least 2.

Ports:
- `wclk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `din` in 8: loader byte.
- `din_valid` in 1: one-cycle strobe per byte.
- `loading` in 1: high while the loader is streaming.
- `hdr_map_ctrl` out 8: header byte 0.
- `hdr_rom_type` out 8: header byte 1.
- `hdr_rom_size` out 8: header byte 2.
- `hdr_ram_size` out 8: header byte 3.
- `hdr_valid` out 1: high once all 64 header bytes have been received.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 16: word data.
- `mem_be` out 2: byte enables, {high, low}.
- `mem_req` out 1: write request.
- `mem_ack` in 1: one-cycle acknowledge for the current write.
- `byte_count` out 24: payload bytes accepted.
- `busy` out 1: high in HEADER, PAYLOAD or FLUSH.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; a byte arrived while the FIFO was full.

## Operation
- States: IDLE → HEADER → PAYLOAD → FLUSH → DONE.
- IDLE: the first `din_valid` while `loading` is high enters HEADER and counts as header byte 0.
- HEADER: header index 0..63. Bytes 0–3 latch the `hdr_*` outputs; bytes 4–63 are discarded. Byte 63 sets `hdr_valid` and moves to PAYLOAD.
- PAYLOAD: payload byte n goes to ROM byte address n.
  - Even n: held in the pair register.
  - Odd n: pushes {byte n, byte n−1} with be=2'b11 at word address n>>1.
  - `byte_count` increments on every payload byte.
- `loading` falling (seen high→low) in HEADER or PAYLOAD moves to FLUSH.
  - If a lone even byte is pending, FLUSH pushes it with be=2'b01, high byte 0.
- FLUSH → DONE once the FIFO is empty and no request is outstanding.
- DONE holds until reset. A rising `loading` in DONE re-enters IDLE, clears `hdr_valid`, `byte_count` and the address, and keeps `overflow`.
- FIFO is full and a push is due: the word is dropped, `overflow` is set, addressing continues.
- Address wrap at 2^ADDR_W words is modulo; no error.
- `loading` low in IDLE: no bytes are accepted.

## Timing
- Reset values: all `hdr_*` = 0, `hdr_valid` = 0, `mem_req` = 0, `mem_addr`/`mem_wdata` = 0, `mem_be` = 0, `byte_count` = 0, `busy` = 0, `done` = 0, `overflow` = 0. State = IDLE, FIFO empty.
- Header outputs update the cycle after the corresponding `din_valid`.
- Word push happens the cycle after the odd byte's `din_valid`.
- `mem_req` rises the cycle after the FIFO becomes non-empty and the previous write is acked.
- `mem_addr`/`mem_wdata`/`mem_be` are stable while `mem_req` is high.
- Ack cycle: the FIFO pops and `mem_req` drops for at least one cycle. Max throughput is one write per 2 cycles.
- `mem_ack` while `mem_req` is low is ignored.
- Push and pop in the same cycle are allowed; the count is unchanged and a full FIFO accepts the push.
- `done` asserts the cycle after the last ack (or the cycle after FLUSH entry if nothing is pending).
- Input rate: one byte per 2 cycles max. Back-to-back `din_valid` must still be accepted.
- Reset mid-operation: outstanding `mem_req` is abandoned and no further write is issued.

## Structure
- Shared package `loader_pkg`:
  - state enum `sink_state_t`.
  - `HDR_LEN` = 64, `HDR_PAD_END` = 512 (loader-side skip, for reference).
  - header byte offsets.
- Sub-module `sync_fifo` (width 2+ADDR_W+16, depth FIFO_DEPTH, with full/empty/count).
- Top: FSM, header capture and byte pairing.

## Test plan
- Header capture: 64 bytes with bytes 0–3 = 21,02,0A,03, then `loading` low → `hdr_*` = 21/02/0A/03, `hdr_valid` = 1, no `mem_req`, `done` = 1.
- Even payload: header + bytes 11,22,33,44, ack after 1 cycle → writes (0,2211,11), (1,4433,11), `byte_count` = 4, `done` = 1.
- Odd tail: header + 11,22,33 → writes (0,2211,11), (1,0033,01).
- Back-pressure: hold `mem_ack` low for 20 cycles during 16 payload bytes at one byte per 2 cycles, FIFO_DEPTH = 4 → `overflow` = 1 and exactly 4 words are written after ack resumes, all with their original addresses.
- Reset mid-payload with `mem_req` high → all outputs return to reset values next cycle and no write is issued.
- Reload: after DONE, `loading` rises again → `hdr_valid` clears, second image writes start at address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state type, header layout and constants for the ROM loader sink
package loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_FLUSH,
    S_DONE
  } sink_state_t;
  localparam int HDR_LEN      = 64;
  localparam int HDR_PAD_END  = 512;
  localparam int HDR_MAP_CTRL = 0;
  localparam int HDR_ROM_TYPE = 1;
  localparam int HDR_ROM_SIZE = 2;
  localparam int HDR_RAM_SIZE = 3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   wclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rp];
  // pointer and occupancy tracking; a full FIFO still takes a push when popping
  always_ff @(posedge wclk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= do_push ? wp + 1'b1 : wp;
      rp    <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage array, not reset
  always_ff @(posedge wclk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/rom_stream_sink.sv
// rom_stream_sink: captures the ROM header and writes payload words to SDRAM
module rom_stream_sink
  import loader_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              loading,
  output logic [7:0]        hdr_map_ctrl,
  output logic [7:0]        hdr_rom_type,
  output logic [7:0]        hdr_rom_size,
  output logic [7:0]        hdr_ram_size,
  output logic              hdr_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [23:0]       byte_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int FW = 2 + ADDR_W + 16;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  sink_state_t state, state_next;
  logic              loading_q, rise, fall;
  logic [5:0]        hdr_idx;
  logic [7:0]        pair;
  logic              pair_pending;
  logic [ADDR_W-1:0] waddr;
  logic              push_v;
  logic [FW-1:0]     push_d, fifo_rdata;
  logic              fifo_full, fifo_empty, pop, drained;
  logic [CW-1:0]     fifo_count;
  assign rise    = loading && !loading_q;
  assign fall    = loading_q && !loading;
  assign pop     = mem_req && mem_ack;
  assign drained = !push_v && !pair_pending && (fifo_empty || (fifo_count == CW'(1) && pop));
  assign busy    = state inside {S_HEADER, S_PAYLOAD, S_FLUSH};
  assign done    = state == S_DONE;
  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk  (wclk),
    .reset (reset),
    .push  (push_v),
    .wdata (push_d),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  // state register
  always_ff @(posedge wclk) begin
    state <= reset ? S_IDLE : state_next;
  end
  // next-state: a loading fall in HEADER/PAYLOAD always wins over byte progress
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    state_next = (din_valid && loading) ? S_HEADER : S_IDLE;
      S_HEADER:  state_next = fall ? S_FLUSH : (din_valid && hdr_idx == 6'(HDR_LEN - 1)) ? S_PAYLOAD : S_HEADER;
      S_PAYLOAD: state_next = fall ? S_FLUSH : S_PAYLOAD;
      S_FLUSH:   state_next = drained ? S_DONE : S_FLUSH;
      S_DONE:    state_next = rise ? S_IDLE : S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end
  // header capture, byte pairing, word staging and the SDRAM write port
  always_ff @(posedge wclk) begin
    if (reset) begin
      loading_q    <= 1'b0;
      hdr_idx      <= '0;
      hdr_map_ctrl <= '0;
      hdr_rom_type <= '0;
      hdr_rom_size <= '0;
      hdr_ram_size <= '0;
      hdr_valid    <= 1'b0;
      pair         <= '0;
      pair_pending <= 1'b0;
      waddr        <= '0;
      byte_count   <= '0;
      push_v       <= 1'b0;
      push_d       <= '0;
      overflow     <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
    end else begin
      loading_q <= loading;
      push_v    <= 1'b0;
      if (state == S_IDLE && din_valid && loading) begin
        hdr_map_ctrl <= din;
        hdr_idx      <= 6'(HDR_MAP_CTRL + 1);
      end
      if (state == S_HEADER && din_valid) begin
        if (hdr_idx == 6'(HDR_ROM_TYPE)) hdr_rom_type <= din;
        if (hdr_idx == 6'(HDR_ROM_SIZE)) hdr_rom_size <= din;
        if (hdr_idx == 6'(HDR_RAM_SIZE)) hdr_ram_size <= din;
        if (hdr_idx == 6'(HDR_LEN - 1)) hdr_valid <= 1'b1;
        hdr_idx <= hdr_idx + 6'd1;
      end
      if (state == S_PAYLOAD && din_valid) begin
        byte_count   <= byte_count + 24'd1;
        pair         <= din;
        pair_pending <= !pair_pending;
        if (pair_pending) begin
          push_v <= 1'b1;
          push_d <= {2'b11, waddr, din, pair};
          waddr  <= waddr + 1'b1;
        end
      end
      if (state == S_FLUSH && pair_pending) begin
        push_v       <= 1'b1;
        push_d       <= {2'b01, waddr, 8'h00, pair};
        waddr        <= waddr + 1'b1;
        pair_pending <= 1'b0;
      end
      if (state == S_DONE && rise) begin
        hdr_valid    <= 1'b0;
        byte_count   <= '0;
        waddr        <= '0;
        pair_pending <= 1'b0;
      end
      if (push_v && fifo_full && !pop) overflow <= 1'b1;
      if (pop) begin
        mem_req <= 1'b0;
      end else if (!mem_req && !fifo_empty) begin
        mem_req                       <= 1'b1;
        {mem_be, mem_addr, mem_wdata} <= fifo_rdata;
      end
    end
  end
endmodule
